// File: rtl/descriptor_scheduler_pkg.sv
// Shared types for the descriptor scheduler: FSM state encoding and the
// MPRF descriptor address width.
package descriptor_sched_pkg;

    localparam int DESC_ADDR_W = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START0    = 3'd1,
        START1    = 3'd2,
        WAIT_BUSY = 3'd3,
        RUN       = 3'd4,
        DONE      = 3'd5
    } sched_state_e;

endpackage

// File: rtl/descriptor_scheduler_if.sv
// Requester and engine-facing signal bundle of the descriptor scheduler.
// master = requesters/engine/sink side, slave = the scheduler itself.
interface descriptor_scheduler_if #(
    parameter int NUM_REQ = 4
);
    import descriptor_sched_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*DESC_ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             done;
    logic                           err;
    logic                           eng_start;
    logic [DESC_ADDR_W-1:0]         eng_start_addr;
    logic                           eng_idle;
    logic                           eng_out_valid;
    logic                           eng_descriptor_allowed;
    logic                           credit_return;
    logic                           busy;

    modport master (
        output req_valid, req_addr, eng_idle, eng_out_valid, credit_return,
        input  req_ready, done, err, eng_start, eng_start_addr,
               eng_descriptor_allowed, busy
    );

    modport slave (
        input  req_valid, req_addr, eng_idle, eng_out_valid, credit_return,
        output req_ready, done, err, eng_start, eng_start_addr,
               eng_descriptor_allowed, busy
    );

endinterface

// File: rtl/descriptor_scheduler_sva.sv
// Simulation checks for the scheduler: no credit return into a full sink
// counter, and the engine start strobe never exceeds two cycles.
module descriptor_scheduler_sva #(
    parameter int CREDITS = 8,
    parameter int CRED_W  = 4
) (
    input logic              clk,
    input logic              rst_n,
    input logic              credit_return_i,
    input logic [CRED_W-1:0] credit_q_i,
    input logic              eng_start_i
);

    credit_full_return_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(credit_return_i && (credit_q_i == CRED_W'(CREDITS))));

    start_two_cycles_a: assert property (@(posedge clk) disable iff (!rst_n)
        (eng_start_i && $past(eng_start_i)) |=> !eng_start_i);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after
// ptr_i, wrapping around. Reusable for any N-way port arbitration.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand_s;

    // Scan from the pointer and keep the first requester found.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = IW'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[cand_s]) begin
                any_o           = 1'b1;
                grant_o[cand_s] = 1'b1;
                idx_o           = cand_s;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/descriptor_scheduler.sv
// Shares one descriptor engine among NUM_REQ requesters: round-robin grant,
// two-cycle start, busy/idle tracking with timeout, and sink credit throttling.
module descriptor_scheduler
    import descriptor_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CREDITS = 8,
    parameter int TIMEOUT = 1024
) (
    input logic                   clk,
    input logic                   rst_n,
    descriptor_scheduler_if.slave bus
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CRED_W = $clog2(CREDITS + 1);
    localparam int TMO_W  = $clog2(TIMEOUT);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    sched_state_e           state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [DESC_ADDR_W-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                   err_q, err_d;
    logic [CRED_W-1:0]      credit_q, credit_d;

    logic [NUM_REQ-1:0]     gnt_s;
    logic [IDX_W-1:0]       gnt_idx_s;
    logic                   gnt_any_s;
    logic [NUM_REQ-1:0]     req_ready_s;
    logic [NUM_REQ-1:0]     done_s;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_q),
        .grant_o (gnt_s),
        .idx_o   (gnt_idx_s),
        .any_o   (gnt_any_s)
    );

    // FSM and job context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_q      <= '0;
            addr_q    <= '0;
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
            credit_q  <= CRED_MAX;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            addr_q    <= addr_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
            credit_q  <= credit_d;
        end
    end

    // Next-state logic; the timeout check wins over a same-cycle engine event.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        addr_d      = addr_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
        req_ready_s = '0;
        case (state_q)
            IDLE: begin
                if (gnt_any_s && rst_n) begin
                    req_ready_s = gnt_s;
                    owner_d     = gnt_idx_s;
                    addr_d      = bus.req_addr[gnt_idx_s*DESC_ADDR_W +: DESC_ADDR_W];
                    err_d       = 1'b0;
                    state_d     = START0;
                end else begin
                    state_d = IDLE;
                end
            end
            START0: state_d = START1;
            START1: begin
                tmo_cnt_d = '0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY, RUN: begin
                if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (state_q == WAIT_BUSY) begin
                        state_d = bus.eng_idle ? WAIT_BUSY : RUN;
                    end else begin
                        state_d = bus.eng_idle ? DONE : RUN;
                    end
                end
            end
            DONE: begin
                rr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sink credits: a write and a return in the same cycle cancel out.
    always_comb begin
        credit_d = credit_q;
        if (bus.eng_out_valid && !bus.credit_return && (credit_q != '0)) begin
            credit_d = credit_q - 1'b1;
        end else if (bus.credit_return && !bus.eng_out_valid && (credit_q != CRED_MAX)) begin
            credit_d = credit_q + 1'b1;
        end else begin
            credit_d = credit_q;
        end
    end

    // Completion strobe routed to the owner of the finishing job.
    always_comb begin
        done_s = '0;
        if (state_q == DONE) begin
            done_s[owner_q] = 1'b1;
        end else begin
            done_s = '0;
        end
    end

    assign bus.req_ready      = req_ready_s;
    assign bus.done           = done_s;
    assign bus.err            = (state_q == DONE) & err_q;
    assign bus.eng_start      = (state_q == START0) | (state_q == START1);
    assign bus.eng_start_addr = addr_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.eng_descriptor_allowed =
        ((state_q == START1) | (state_q == WAIT_BUSY) | (state_q == RUN)) & (credit_q != '0);

    descriptor_scheduler_sva #(.CREDITS(CREDITS), .CRED_W(CRED_W)) u_sva (
        .clk             (clk),
        .rst_n           (rst_n),
        .credit_return_i (bus.credit_return),
        .credit_q_i      (credit_q),
        .eng_start_i     (bus.eng_start)
    );

endmodule
